// File: rtl/vote_pkg.sv
// Shared types, helpers and default timing for the vote button front end.
package vote_pkg;

  // Per-channel press state.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    LOCK = 2'd2,
    REL  = 2'd3
  } btn_state_t;

  // Default timing, in clock cycles.
  localparam int unsigned DEF_NUM_BTN        = 4;
  localparam int unsigned DEF_HOLD_CYCLES    = 100_000_000;
  localparam int unsigned DEF_RELEASE_CYCLES = 1_000_000;
  localparam int unsigned DEF_SYNC_STAGES    = 2;

  // Bits needed to index n values, never less than 1.
  function automatic int unsigned clog2_min1(input int unsigned n);
    int unsigned r;
    r = (n <= 1) ? 1 : $clog2(n);
    return r;
  endfunction

  // Larger of two cycle counts.
  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    int unsigned r;
    r = (a > b) ? a : b;
    return r;
  endfunction

endpackage : vote_pkg

// File: rtl/vote_btn_channel.sv
// One button channel: input synchroniser, hold/release counter and press FSM.
// qual is a registered one-cycle pulse on the HOLD->LOCK transition.
module vote_btn_channel
  import vote_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES    = DEF_HOLD_CYCLES,
  parameter int unsigned RELEASE_CYCLES = DEF_RELEASE_CYCLES,
  parameter int unsigned SYNC_STAGES    = DEF_SYNC_STAGES
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic       button,
  output logic       qual,
  output btn_state_t state
);

  localparam int unsigned MAX_CYC = max_u(HOLD_CYCLES, RELEASE_CYCLES);
  localparam int unsigned CNT_W   = clog2_min1(MAX_CYC + 1);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REL_LAST  = CNT_W'(RELEASE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0]       cnt;
  logic                   s;

  assign s = sync_q[SYNC_STAGES-1];

  // Synchroniser chain for the asynchronous button.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], button};
    end
  end

  // Press FSM with its cycle counter; leaving a state at terminal count keeps cnt bounded.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= CNT_ZERO;
      qual  <= 1'b0;
    end else begin
      qual <= 1'b0;
      unique case (state)
        IDLE: begin
          cnt <= CNT_ZERO;
          if (s && enable) begin
            state <= HOLD;
            cnt   <= CNT_ONE;
          end
        end
        HOLD: begin
          if (!s || !enable) begin
            state <= IDLE;
            cnt   <= CNT_ZERO;
          end else if (cnt == HOLD_LAST) begin
            state <= LOCK;
            cnt   <= CNT_ZERO;
            qual  <= 1'b1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        LOCK: begin
          cnt <= CNT_ZERO;
          if (!s) begin
            // A single clean low sample already satisfies a one-cycle release.
            if (RELEASE_CYCLES == 1) begin
              state <= IDLE;
            end else begin
              state <= REL;
              cnt   <= CNT_ONE;
            end
          end
        end
        REL: begin
          if (s) begin
            state <= LOCK;
            cnt   <= CNT_ZERO;
          end else if (cnt == REL_LAST) begin
            state <= IDLE;
            cnt   <= CNT_ZERO;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= CNT_ZERO;
        end
      endcase
    end
  end

endmodule : vote_btn_channel

// File: rtl/vote_button_array.sv
// Multi-channel press qualifier: per-channel FSMs plus a single-winner arbiter.
// A vote needs exactly one qualifying channel with every other channel idle;
// anything else that qualifies is flagged as a conflict.
module vote_button_array
  import vote_pkg::*;
#(
  parameter int unsigned NUM_BTN        = DEF_NUM_BTN,
  parameter int unsigned HOLD_CYCLES    = DEF_HOLD_CYCLES,
  parameter int unsigned RELEASE_CYCLES = DEF_RELEASE_CYCLES,
  parameter int unsigned SYNC_STAGES    = DEF_SYNC_STAGES,
  localparam int unsigned IDX_W         = clog2_min1(NUM_BTN),
  localparam int unsigned POP_W         = clog2_min1(NUM_BTN + 1)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  input  logic [NUM_BTN-1:0] button,
  output logic               vote_valid,
  output logic [IDX_W-1:0]   vote_idx,
  output logic [NUM_BTN-1:0] vote_onehot,
  output logic               conflict,
  output logic               busy
);

  logic [NUM_BTN-1:0] qual;
  logic [NUM_BTN-1:0] not_idle;
  btn_state_t         state [NUM_BTN];

  logic [POP_W-1:0]   qual_cnt;
  logic [IDX_W-1:0]   qual_idx;
  logic               other_busy;
  logic               vote_c;
  logic               conflict_c;

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_chan
    vote_btn_channel #(
      .HOLD_CYCLES    (HOLD_CYCLES),
      .RELEASE_CYCLES (RELEASE_CYCLES),
      .SYNC_STAGES    (SYNC_STAGES)
    ) u_chan (
      .clock  (clock),
      .reset  (reset),
      .enable (enable),
      .button (button[g]),
      .qual   (qual[g]),
      .state  (state[g])
    );
    assign not_idle[g] = (state[g] != IDLE);
  end

  // Popcount, index encoder and busy-neighbour check over the qual vector.
  always_comb begin
    qual_cnt = '0;
    qual_idx = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      qual_cnt = qual_cnt + POP_W'(qual[i]);
      if (qual[i]) begin
        qual_idx = IDX_W'(i);
      end
    end
    // A qualifying channel is itself in LOCK, so only non-qualifying channels count.
    other_busy = |(not_idle & ~qual);
    vote_c     = (qual_cnt == POP_W'(1)) && !other_busy;
    conflict_c = (qual_cnt > POP_W'(1)) || ((qual_cnt == POP_W'(1)) && other_busy);
  end

  // Output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      vote_valid  <= 1'b0;
      vote_idx    <= '0;
      vote_onehot <= '0;
      conflict    <= 1'b0;
      busy        <= 1'b0;
    end else begin
      vote_valid  <= vote_c;
      vote_idx    <= vote_c ? qual_idx : '0;
      vote_onehot <= vote_c ? qual : '0;
      conflict    <= conflict_c;
      busy        <= |not_idle;
    end
  end

endmodule : vote_button_array

// File: tb/tb_vote_button_array.sv
// Randomised bench for vote_button_array against a run-length reference model.
module tb_vote_button_array;

  localparam int NB   = 4;
  localparam int HOLD = 8;
  localparam int RELC = 4;
  localparam int SYNC = 2;

  logic          clock;
  logic          reset;
  logic          enable;
  logic [NB-1:0] button;
  logic          vote_valid;
  logic [1:0]    vote_idx;
  logic [NB-1:0] vote_onehot;
  logic          conflict;
  logic          busy;

  vote_button_array #(
    .NUM_BTN        (NB),
    .HOLD_CYCLES    (HOLD),
    .RELEASE_CYCLES (RELC),
    .SYNC_STAGES    (SYNC)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .enable      (enable),
    .button      (button),
    .vote_valid  (vote_valid),
    .vote_idx    (vote_idx),
    .vote_onehot (vote_onehot),
    .conflict    (conflict),
    .busy        (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int vectors    = 0;
  int miscompares = 0;

  // Reference model: each channel is either armed (waiting for a long enough
  // enabled press) or disarmed (waiting for a long enough clean release).
  // run counts the current qualifying run of samples.
  bit            armed   [NB];
  int            run     [NB];
  bit            q       [NB];
  bit [SYNC-1:0] hist    [NB];
  bit            m_valid;
  int            m_idx;
  bit [NB-1:0]   m_onehot;
  bit            m_conflict;
  bit            m_busy;

  int edge_no    = 0;
  int votes_seen = 0;
  int confl_seen = 0;
  int vote_edge  = -1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s @edge %0d: got %0h expected %0h", tag, edge_no, got, exp);
    end
  endtask

  function automatic bit is_idle(input int ch);
    return armed[ch] && (run[ch] == 0);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NB; i++) begin
      armed[i] = 1'b1;
      run[i]   = 0;
      q[i]     = 1'b0;
      hist[i]  = '0;
    end
    m_valid = 0; m_idx = 0; m_onehot = '0; m_conflict = 0; m_busy = 0;
  endtask

  task automatic model_step();
    int  nq;
    int  widx;
    bit  others;
    bit  s;
    if (reset) begin
      model_reset();
      return;
    end
    nq = 0; widx = 0; others = 0; m_busy = 0;
    for (int i = 0; i < NB; i++) begin
      if (q[i]) begin nq++; widx = i; end
      else if (!is_idle(i)) others = 1;
      if (!is_idle(i)) m_busy = 1;
    end
    m_valid    = (nq == 1) && !others;
    m_idx      = m_valid ? widx : 0;
    m_onehot   = m_valid ? (NB'(1) << widx) : '0;
    m_conflict = (nq >= 2) || ((nq == 1) && others);
    for (int i = 0; i < NB; i++) begin
      s       = hist[i][SYNC-1];
      hist[i] = {hist[i][SYNC-2:0], button[i]};
      q[i]    = 1'b0;
      if (armed[i]) begin
        run[i] = (s && enable) ? run[i] + 1 : 0;
        if (run[i] == HOLD) begin
          q[i] = 1'b1; armed[i] = 1'b0; run[i] = 0;
        end
      end else begin
        run[i] = s ? 0 : run[i] + 1;
        if (run[i] == RELC) begin
          armed[i] = 1'b1; run[i] = 0;
        end
      end
    end
  endtask

  // One clock: model follows the edge, outputs are compared at the falling edge.
  task automatic tick();
    @(posedge clock);
    edge_no++;
    model_step();
    @(negedge clock);
    check_eq("vote_valid", 32'(vote_valid), 32'(m_valid));
    check_eq("vote_idx", 32'(vote_idx), 32'(m_idx));
    check_eq("vote_onehot", 32'(vote_onehot), 32'(m_onehot));
    check_eq("conflict", 32'(conflict), 32'(m_conflict));
    check_eq("busy", 32'(busy), 32'(m_busy));
    if (vote_valid) begin votes_seen++; vote_edge = edge_no; end
    if (conflict) confl_seen++;
  endtask

  task automatic run_cycles(input int n, input logic [NB-1:0] b);
    button = b;
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic clear_counts();
    votes_seen = 0; confl_seen = 0; vote_edge = -1;
  endtask

  initial begin
    int start;
    int seg_len;
    int kind;
    model_reset();
    reset = 1'b1; enable = 1'b1; button = '0;
    run_cycles(2, '0);
    reset = 1'b0;
    run_cycles(3, '0);

    // Single press on channel 2: one vote, fixed latency.
    clear_counts();
    start = edge_no + 1;
    run_cycles(20, 4'b0100);
    run_cycles(8, '0);
    check_eq("A_votes", 32'(votes_seen), 32'd1);
    check_eq("A_latency", 32'(vote_edge - start), 32'(SYNC + HOLD));
    check_eq("A_conflicts", 32'(confl_seen), 32'd0);

    // Glitchy press on channel 1: count restarts, still one vote.
    clear_counts();
    run_cycles(5, 4'b0010);
    run_cycles(1, '0);
    start = edge_no + 1;
    run_cycles(20, 4'b0010);
    run_cycles(8, '0);
    check_eq("B_votes", 32'(votes_seen), 32'd1);
    check_eq("B_latency", 32'(vote_edge - start), 32'(SYNC + HOLD));

    // Simultaneous channels 0 and 3: conflict, then channel 3 alone.
    clear_counts();
    run_cycles(14, 4'b1001);
    check_eq("C_conflicts", 32'(confl_seen), 32'd1);
    check_eq("C_votes0", 32'(votes_seen), 32'd0);
    run_cycles(8, '0);
    run_cycles(12, 4'b1000);
    run_cycles(8, '0);
    check_eq("C_votes1", 32'(votes_seen), 32'd1);

    // Release bounce on channel 0, then a second press.
    clear_counts();
    run_cycles(12, 4'b0001);
    run_cycles(2, '0);
    run_cycles(1, 4'b0001);
    run_cycles(8, '0);
    run_cycles(12, 4'b0001);
    run_cycles(8, '0);
    check_eq("D_votes", 32'(votes_seen), 32'd2);

    // Held with the window closed, then window opens.
    clear_counts();
    enable = 1'b0;
    run_cycles(30, 4'b0010);
    check_eq("E_votes_closed", 32'(votes_seen), 32'd0);
    enable = 1'b1;
    run_cycles(12, 4'b0010);
    run_cycles(8, '0);
    check_eq("E_votes_open", 32'(votes_seen), 32'd1);

    // Reset in the middle of a hold: only a fresh full hold may vote.
    clear_counts();
    run_cycles(7, 4'b0100);
    reset = 1'b1;
    run_cycles(1, 4'b0100);
    check_eq("F_busy_rst", 32'(busy), 32'd0);
    reset = 1'b0;
    run_cycles(6, 4'b0100);
    check_eq("F_votes_early", 32'(votes_seen), 32'd0);
    run_cycles(8, 4'b0100);
    run_cycles(8, '0);
    check_eq("F_votes", 32'(votes_seen), 32'd1);

    // Random segments of held patterns, window toggling and occasional reset.
    for (int seg = 0; seg < 300; seg++) begin
      seg_len = $urandom_range(1, 14);
      kind    = $urandom_range(0, 9);
      case (kind)
        0, 1:    button = '0;
        2, 3, 4: button = NB'(1) << $urandom_range(0, NB - 1);
        5:       button = (NB'(1) << $urandom_range(0, NB - 1)) | (NB'(1) << $urandom_range(0, NB - 1));
        default: button = NB'($urandom);
      endcase
      enable = ($urandom_range(0, 7) != 0);
      reset  = ($urandom_range(0, 39) == 0);
      tick();
      reset = 1'b0;
      for (int k = 1; k < seg_len; k++) tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_vote_button_array
